// File: rtl/key_conditioner.sv
// Button conditioner: 2-FF synchroniser, stable-count debouncer, press/release pulses and an
// optional hold-to-repeat generator enabled by defining KEY_CONDITIONER_AUTOREPEAT_EN.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic async_reset,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_event
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic            level_d;
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic            press_q;
  logic            press_d;
  logic            release_q;
  logic            release_d;
  logic            event_q;

  // Debounce next-state; press/release are derived from the level change so they line up with it.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = {DB_W{1'b0}};
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = {DB_W{1'b0}};
    end
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      db_cnt_q  <= {DB_W{1'b0}};
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      db_cnt_q  <= db_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_V  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD_V = RPT_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } rpt_state_e;

  rpt_state_e       state_q;
  logic [RPT_W-1:0] rpt_cnt_q;

  // Repeat FSM tracks the next-state level so the delay starts in the same cycle key_press shows.
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      state_q   <= RELEASED;
      rpt_cnt_q <= {RPT_W{1'b0}};
      event_q   <= 1'b0;
    end else begin
      event_q <= press_d;
      case (state_q)
        RELEASED: begin
          if (press_d) begin
            state_q   <= HELD_DELAY;
            rpt_cnt_q <= RPT_W'(1);
          end
        end
        HELD_DELAY: begin
          if (!level_d) begin
            state_q   <= RELEASED;
            rpt_cnt_q <= {RPT_W{1'b0}};
          end else if (rpt_cnt_q == RPT_DELAY_V) begin
            event_q   <= 1'b1;
            state_q   <= HELD_REPEAT;
            rpt_cnt_q <= RPT_W'(1);
          end else begin
            rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
          end
        end
        HELD_REPEAT: begin
          if (!level_d) begin
            state_q   <= RELEASED;
            rpt_cnt_q <= {RPT_W{1'b0}};
          end else if (rpt_cnt_q == RPT_PERIOD_V) begin
            event_q   <= 1'b1;
            rpt_cnt_q <= RPT_W'(1);
          end else begin
            rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
          end
        end
        default: begin
          state_q   <= RELEASED;
          rpt_cnt_q <= {RPT_W{1'b0}};
        end
      endcase
    end
  end
`else
  // Without auto-repeat the event strobe is just the press pulse.
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      event_q <= 1'b0;
    end else begin
      event_q <= press_d;
    end
  end
`endif

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_event   = event_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: a cycle model predicts all four outputs per edge,
// a separate monitor pops and compares them on the falling edge.
module tb_key_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic async_reset;
  logic key_raw;
  logic key_level, key_press, key_release, key_event;

  int n_cmp = 0;
  int n_bad = 0;
  bit done_s = 1'b0;

  logic [3:0] exp_q[$];

  key_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .async_reset(async_reset),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_event  (key_event)
  );

  always #5 clk = ~clk;

  // Reference model state: raw samples delayed two edges, a run length of disagreeing
  // samples, and the edge index of the last press for the repeat schedule.
  bit m_d1, m_d2, m_lvl;
  int m_run, m_edge, m_press_edge;

  task automatic model_step();
    bit cmp, pr, rl, rp;
    int k;
    logic [3:0] e;
    pr = 1'b0; rl = 1'b0; rp = 1'b0;
    if (!async_reset) begin
      m_d1 = 1'b0; m_d2 = 1'b0; m_lvl = 1'b0;
      m_run = 0; m_edge = 0; m_press_edge = 0;
      e = 4'b0000;
    end else begin
      m_edge++;
      cmp  = m_d2;
      m_d2 = m_d1;
      m_d1 = key_raw;
      if (cmp != m_lvl) m_run++;
      else m_run = 0;
      if (m_run == DB) begin
        m_lvl = cmp;
        m_run = 0;
        pr = m_lvl;
        rl = !m_lvl;
        if (m_lvl) m_press_edge = m_edge;
      end
      if (AR && m_lvl && !pr) begin
        k  = m_edge - m_press_edge;
        rp = (k == RD) || (k > RD && ((k - RD) % RP) == 0);
      end
      e = {m_lvl, pr, rl, pr | rp};
    end
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: outputs are presented every cycle, compared away from the active edge.
  initial begin
    logic [3:0] exp_v;
    logic [3:0] act_v;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        if (!async_reset) exp_v = 4'b0000;
        act_v = {key_level, key_press, key_release, key_event};
        n_cmp++;
        if (act_v !== exp_v) begin
          n_bad++;
          $display("FAIL outputs t=%0t lvl/press/rel/event actual=%b expected=%b", $time, act_v, exp_v);
        end
      end
    end
  end

  // Watchdog: the stimulus must finish within a bounded time.
  initial begin
    #1000000;
    if (!done_s) begin
      n_bad++;
      $display("FAIL timeout t=%0t stimulus did not complete", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  // Direct check that all outputs are 0 while reset is held.
  task automatic check_reset_state();
    n_cmp++;
    if ({key_level, key_press, key_release, key_event} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset state t=%0t outputs=%b expected=0000", $time,
               {key_level, key_press, key_release, key_event});
    end
  endtask

  // Called 3 time units after a rising edge; drives the level then waits n edges.
  task automatic hold(input logic v, input int n);
    key_raw = v;
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic reset_pulse(input logic v, input int n);
    async_reset = 1'b0;
    hold(v, n);
    async_reset = 1'b1;
  endtask

  initial begin
    async_reset = 1'b0;
    key_raw     = 1'b0;
    @(posedge clk);
    #3;
    check_reset_state();
    hold(1'b0, 3);
    check_reset_state();
    async_reset = 1'b1;
    hold(1'b0, 20);
    // clean press then release
    hold(1'b1, 8);
    hold(1'b0, 12);
    // short glitches must not pass
    hold(1'b1, 1);
    hold(1'b0, 6);
    hold(1'b1, 3);
    hold(1'b0, 6);
    // long hold for repeat pulses
    hold(1'b1, 45);
    hold(1'b0, 12);
    // release shortly after the first repeat, then a fresh press
    hold(1'b1, 18);
    hold(1'b0, 10);
    hold(1'b1, 20);
    hold(1'b0, 10);
    // key held across reset release counts as a new press
    key_raw = 1'b1;
    async_reset = 1'b0;
    #1;
    check_reset_state();
    hold(1'b1, 3);
    async_reset = 1'b1;
    hold(1'b1, 20);
    hold(1'b0, 10);
    // reset in the middle of a repeat hold
    hold(1'b1, 14);
    reset_pulse(1'b1, 2);
    hold(1'b1, 15);
    hold(1'b0, 10);
    // randomized segments with occasional resets
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 14) == 0) begin
        reset_pulse(1'($urandom_range(0, 1)), $urandom_range(1, 2));
      end else begin
        hold(1'($urandom_range(0, 1)), $urandom_range(1, 16));
      end
    end
    hold(1'b0, 12);
    @(negedge clk);
    #1;
    done_s = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
